// File: rtl/sw_pkg.sv
// ============================================================================
// sw_pkg : shared types and defaults for the stopwatch trigger controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package sw_pkg;

    localparam int SW_STATE_W              = 2;
    localparam int C_DEF_DEBOUNCE_CYCLES   = 500000;
    localparam int C_DEF_LONG_PRESS_CYCLES = 100000000;

    typedef enum logic [SW_STATE_W-1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        STOPPED = 2'd2
    } sw_state_t;

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// sw_debounce : 2-FF synchroniser followed by a consecutive-cycle debounce filter
// Revision: 1.0
// ============================================================================
`default_nettype none

module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = sw_pkg::C_DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_level
);

    localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [C_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
            // Any cycle of agreement restarts the count, so short glitches never flip the level
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/sw_trigger_ctrl.sv
// ============================================================================
// sw_trigger_ctrl : debounced button -> short/long press -> start/stop/clear FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module sw_trigger_ctrl
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = C_DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = C_DEF_LONG_PRESS_CYCLES
) (
    input  logic                  i_sclk,
    input  logic                  i_reset,
    input  logic                  i_trigger,
    output logic                  o_run,
    output logic                  o_clear,
    output logic [SW_STATE_W-1:0] o_state,
    output logic                  o_pressed
);

    localparam int                  C_HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_MAX  = C_HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_ONE  = C_HOLD_W'(1);

    logic                w_pressed;
    logic                r_pressed_d;
    logic [C_HOLD_W-1:0] r_hold;
    logic                r_long_done;
    logic                w_fall;
    logic                w_short;
    logic                w_long;

    sw_state_t           r_state;
    sw_state_t           w_state_nxt;
    logic                w_clear_nxt;
    logic                r_run;
    logic                r_clear;

    sw_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk   (i_sclk),
        .i_rst   (i_reset),
        .i_din   (i_trigger),
        .o_level (w_pressed)
    );

    assign w_fall  = r_pressed_d & ~w_pressed;
    assign w_short = w_fall & ~r_long_done;
    // Strobe in the cycle the counter steps onto its limit, so the FSM acts on that same edge
    assign w_long  = w_pressed & (r_hold == C_HOLD_LAST);

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            r_pressed_d <= 1'b0;
            r_hold      <= '0;
            r_long_done <= 1'b0;
        end else begin
            r_pressed_d <= w_pressed;
            if (!w_pressed) begin
                r_hold <= '0;
            end else if (r_hold != C_HOLD_MAX) begin
                r_hold <= r_hold + C_HOLD_ONE;
            end
            if (w_fall) begin
                r_long_done <= 1'b0;
            end else if (w_long) begin
                r_long_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= (w_state_nxt == RUNNING);
            r_clear <= w_clear_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_short) begin
                    w_state_nxt = RUNNING;
                end else if (w_long) begin
                    w_clear_nxt = 1'b1;
                end
            end
            RUNNING: begin
                if (w_short) begin
                    w_state_nxt = STOPPED;
                end
            end
            STOPPED: begin
                if (w_short) begin
                    w_state_nxt = RUNNING;
                end else if (w_long) begin
                    w_state_nxt = IDLE;
                    w_clear_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_run     = r_run;
    assign o_clear   = r_clear;
    assign o_state   = r_state;
    assign o_pressed = w_pressed;

endmodule

`default_nettype wire

// File: doc/sw_trigger_ctrl.md
Name: sw_trigger_ctrl

Overview:
- Upstream neighbour of the stopwatch timer. Conditions the raw push-button `i_trigger` through a 2-FF synchroniser and a debounce filter, then classifies each press as short or long.
- A start/stop/clear FSM drives a level run-enable and a one-cycle clear pulse into the timer.
- Replaces direct use of the raw trigger as timer enable inside rtc_stopwatch.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive cycles the synchronised input must differ from the debounced level before that level flips (5 ms at 100 MHz); legal range >=2.
- LONG_PRESS_CYCLES, 100000000: debounced-high cycles that classify a press as long (1 s at 100 MHz); must exceed DEBOUNCE_CYCLES.

Ports:
- i_sclk, input, 1: system clock; all logic on the rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_trigger, input, 1: raw asynchronous button level, 1 = pressed.
- o_run, output, 1: registered timer count enable, 1 while state = RUNNING.
- o_clear, output, 1: one-cycle pulse commanding the timer and display to zero.
- o_state, output, 2: current FSM state (IDLE=0, RUNNING=1, STOPPED=2; 3 unused).
- o_pressed, output, 1: debounced button level, for debug/LED.

Behaviour:
- Reset: sampled on the rising edge and dominant over every other event. It forces:
  - sync FFs = 0, debounced level = 0;
  - debounce and hold counters = 0, long_done = 0;
  - state = IDLE, o_run = 0, o_clear = 0, o_pressed = 0.
- Reset while the button is held: the held press is re-debounced after reset and treated as a new press.
- Synchroniser: two FFs, giving 2 cycles of latency to sync2.
- Debounce counter:
  - Clears whenever sync2 == the debounced level.
  - Increments while they differ.
  - When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the debounced level.
  - Pin-to-debounced latency = 2 + DEBOUNCE_CYCLES cycles.
- Hold counter:
  - Counts cycles with debounced = 1; saturates at LONG_PRESS_CYCLES.
  - Cleared on the debounced falling edge.
- Long event:
  - Single-cycle internal strobe in the cycle where the hold counter reaches LONG_PRESS_CYCLES.
  - Sets long_done; long_done is cleared on the debounced falling edge.
- Short event: single-cycle strobe on the debounced falling edge when long_done = 0. A release after a long press generates nothing.
- FSM (registered; outputs change on the edge after the strobe, i.e. 1 cycle of latency):
  - IDLE: short -> RUNNING. long -> stay IDLE and pulse o_clear.
  - RUNNING: short -> STOPPED. long -> ignored; stay RUNNING, and the release is also ignored.
  - STOPPED: short -> RUNNING. long -> IDLE and pulse o_clear.
  - Illegal encoding 3 -> IDLE on the next edge, o_clear = 0.
- o_clear: high for exactly 1 cycle per qualifying long event. Never high in the same cycle as an o_run rising edge.
- End-to-end latency, pin edge to output change:
  - Short press: the FSM acts 2 + DEBOUNCE_CYCLES + 1 cycles after the release edge.
  - Long press: o_clear rises 2 + DEBOUNCE_CYCLES + LONG_PRESS_CYCLES cycles after the press edge.
- Counter widths: $clog2(param+1) bits; no wrap (both counters clear or saturate).

Decomposition:
- Package sw_pkg:
  - sw_state_t enum (IDLE, RUNNING, STOPPED);
  - default DEBOUNCE_CYCLES and LONG_PRESS_CYCLES constants;
  - SW_STATE_W = 2.
- One sub-module, sw_debounce (synchroniser plus filter, parameter DEBOUNCE_CYCLES, output debounced level). Reusable for future buttons.
- Hold counter, press classification and FSM stay in sw_trigger_ctrl.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20):
- Reset:
  - Stimulus: hold i_reset=1 for 3 cycles with i_trigger=1.
  - Required: o_run=0, o_clear=0, o_state=0, o_pressed=0 throughout reset.
  - After release, o_pressed rises 6 cycles later.
- Glitch rejection:
  - Stimulus: i_trigger high for 3 cycles, then low.
  - Required: o_pressed stays 0, o_state stays 0, no o_clear.
- Short start/stop:
  - Stimulus: from IDLE, press for 10 cycles, then release.
  - Required: o_run=1 and o_state=1 exactly 7 cycles after the release edge.
  - A second identical press makes o_state=2, o_run=0.
- Long clear:
  - Stimulus: in STOPPED, hold the press for 40 cycles.
  - Required: o_clear=1 for exactly 1 cycle, 26 cycles after the press edge; o_state=0.
  - The subsequent release gives no state change.
- Long press while running:
  - Stimulus: in RUNNING, hold for 40 cycles, then release.
  - Required: o_run stays 1, o_clear never asserts, o_state stays 1.
- Reset mid-press:
  - Stimulus: in STOPPED, assert i_reset at hold cycle 15, deassert, keep holding 30 more cycles.
  - Required: o_state=0 after reset.
  - One o_clear pulse is produced 26 cycles after reset deassertion (the re-debounced press counts as long in IDLE).
